// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done handshake and result bus for seq_divider
interface seq_divider_if #(parameter int WIDTH = 8);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  modport master(output start, signed_mode, dividend, divisor,
                 input busy, done, quotient, remainder, div_by_zero);
  modport slave(input start, signed_mode, dividend, divisor,
                output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: fixed-latency restoring divider, signed/unsigned, divide-by-zero flag
module seq_divider #(parameter int WIDTH = 8) (
  input logic        clk,
  input logic        rst_n,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FINISH = 2'd2;
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd, dsr, rem;
  logic [WIDTH:0]   trial;
  logic             q_neg, r_neg, sd, sv, ge, dz;
  // operand signs and one restoring step; trial is the widened partial remainder
  always_comb begin
    sd = bus.signed_mode & bus.dividend[WIDTH-1];
    sv = bus.signed_mode & bus.divisor[WIDTH-1];
    dz = bus.divisor == '0;
    trial = {rem, dvd[WIDTH-1]};
    ge = trial >= {1'b0, dsr};
  end
  // control FSM; dvd shifts the dividend out while collecting quotient bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      dvd <= '0;
      dsr <= '0;
      rem <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          dsr <= sv ? -bus.divisor : bus.divisor;
          dvd <= (sd && !dz) ? -bus.dividend : bus.dividend;
          q_neg <= sd ^ sv;
          r_neg <= sd;
          cnt <= CW'(WIDTH);
          rem <= '0;
          bus.busy <= 1'b1;
          state <= dz ? FINISH : CALC;
        end
      end else if (state == CALC) begin
        rem <= ge ? trial[WIDTH-1:0] - dsr : trial[WIDTH-1:0];
        dvd <= {dvd[WIDTH-2:0], ge};
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) state <= FINISH;
      end else begin
        bus.quotient <= dsr == '0 ? '1 : q_neg ? -dvd : dvd;
        bus.remainder <= dsr == '0 ? dvd : r_neg ? -rem : rem;
        bus.div_by_zero <= dsr == '0;
        bus.done <= 1'b1;
        bus.busy <= 1'b0;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider at WIDTH 8, 4 and 16
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  seq_divider_if #(.WIDTH(8))  b8();
  seq_divider_if #(.WIDTH(4))  b4();
  seq_divider_if #(.WIDTH(16)) b16();
  seq_divider #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  seq_divider #(.WIDTH(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(b4));
  seq_divider #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int wid(input int s);
    return s == 0 ? 8 : s == 1 ? 4 : 16;
  endfunction
  function automatic logic done_of(input int s);
    return s == 0 ? b8.done : s == 1 ? b4.done : b16.done;
  endfunction
  function automatic logic busy_of(input int s);
    return s == 0 ? b8.busy : s == 1 ? b4.busy : b16.busy;
  endfunction
  function automatic logic [31:0] q_of(input int s);
    return s == 0 ? 32'(b8.quotient) : s == 1 ? 32'(b4.quotient) : 32'(b16.quotient);
  endfunction
  function automatic logic [31:0] r_of(input int s);
    return s == 0 ? 32'(b8.remainder) : s == 1 ? 32'(b4.remainder) : 32'(b16.remainder);
  endfunction
  function automatic logic [31:0] z_of(input int s);
    return s == 0 ? 32'(b8.div_by_zero) : s == 1 ? 32'(b4.div_by_zero) : 32'(b16.div_by_zero);
  endfunction

  // reference: plain integer division, truncating toward zero
  task automatic model(input int w, input bit sm, input longint a, input longint b,
                       output logic [31:0] q, output logic [31:0] r, output logic [31:0] z);
    longint m, sa, sb;
    m = (longint'(1) << w) - 1;
    if (b == 0) begin
      q = 32'(m);
      r = 32'(a);
      z = 32'd1;
    end else begin
      sa = (sm && a >= (longint'(1) << (w - 1))) ? a - (longint'(1) << w) : a;
      sb = (sm && b >= (longint'(1) << (w - 1))) ? b - (longint'(1) << w) : b;
      q = 32'((sa / sb) & m);
      r = 32'((sa % sb) & m);
      z = 32'd0;
    end
  endtask

  task automatic go(input int s, input bit sm, input logic [15:0] a, input logic [15:0] b);
    case (s)
      0: begin b8.signed_mode = sm; b8.dividend = a[7:0]; b8.divisor = b[7:0]; b8.start = 1'b1; end
      1: begin b4.signed_mode = sm; b4.dividend = a[3:0]; b4.divisor = b[3:0]; b4.start = 1'b1; end
      default: begin b16.signed_mode = sm; b16.dividend = a; b16.divisor = b; b16.start = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    b8.start = 1'b0;
    b4.start = 1'b0;
    b16.start = 1'b0;
    b8.dividend = 8'($urandom);
    b8.divisor = 8'($urandom);
    b4.dividend = 4'($urandom);
    b4.divisor = 4'($urandom);
    b16.dividend = 16'($urandom);
    b16.divisor = 16'($urandom);
  endtask

  task automatic wait_done(input int s, output int n, output int bc);
    bc = int'(busy_of(s));
    n = 0;
    while (!done_of(s) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      bc += int'(busy_of(s));
    end
  endtask

  task automatic run(input int s, input string tag, input bit sm, input logic [15:0] a, input logic [15:0] b);
    int n, bc, w;
    logic [31:0] q, r, z;
    longint am, bm;
    w = wid(s);
    am = longint'(a) & ((longint'(1) << w) - 1);
    bm = longint'(b) & ((longint'(1) << w) - 1);
    go(s, sm, a, b);
    wait_done(s, n, bc);
    model(w, sm, am, bm, q, r, z);
    check({tag, "_lat"}, 32'(n), bm == 0 ? 32'd1 : 32'(w + 1));
    check({tag, "_q"}, q_of(s), q);
    check({tag, "_r"}, r_of(s), r);
    check({tag, "_dz"}, z_of(s), z);
  endtask

  task automatic count_done(input int cycles, output int d);
    d = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      d += int'(b8.done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bc, d;
    b8.start = 1'b0; b8.signed_mode = 1'b0; b8.dividend = '0; b8.divisor = '0;
    b4.start = 1'b0; b4.signed_mode = 1'b0; b4.dividend = '0; b4.divisor = '0;
    b16.start = 1'b0; b16.signed_mode = 1'b0; b16.dividend = '0; b16.divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(b8.busy), 32'd0);
    check("rst_done", 32'(b8.done), 32'd0);
    check("rst_q", q_of(0), 32'd0);
    check("rst_r", r_of(0), 32'd0);
    check("rst_dz", z_of(0), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    go(0, 1'b0, 16'd200, 16'd7);
    check("u200_busy0", 32'(b8.busy), 32'd1);
    wait_done(0, n, bc);
    check("u200_lat", 32'(n), 32'd9);
    check("u200_busycyc", 32'(bc), 32'd9);
    check("u200_q", q_of(0), 32'd28);
    check("u200_r", r_of(0), 32'd4);
    check("u200_dz", z_of(0), 32'd0);
    @(posedge clk);
    #1;
    check("u200_pulse", 32'(b8.done), 32'd0);
    check("u200_hold", q_of(0), 32'd28);
    run(0, "u5_9", 1'b0, 16'd5, 16'd9);
    check("u5_9_qc", q_of(0), 32'd0);
    check("u5_9_rc", r_of(0), 32'd5);
    run(0, "sm7_2", 1'b1, 16'h00F9, 16'h0002);
    check("sm7_2_qc", q_of(0), 32'hFD);
    check("sm7_2_rc", r_of(0), 32'hFF);
    run(0, "s7_m2", 1'b1, 16'h0007, 16'h00FE);
    check("s7_m2_qc", q_of(0), 32'hFD);
    check("s7_m2_rc", r_of(0), 32'h01);
    run(0, "sovf", 1'b1, 16'h0080, 16'h00FF);
    check("sovf_qc", q_of(0), 32'h80);
    check("sovf_rc", r_of(0), 32'h00);
    run(0, "dz37", 1'b0, 16'd37, 16'd0);
    check("dz37_qc", q_of(0), 32'hFF);
    check("dz37_rc", r_of(0), 32'd37);
    check("dz37_zc", z_of(0), 32'd1);
    run(0, "u10_3", 1'b0, 16'd10, 16'd3);
    check("u10_3_qc", q_of(0), 32'd3);
    check("u10_3_rc", r_of(0), 32'd1);
    check("u10_3_zc", z_of(0), 32'd0);
    go(0, 1'b0, 16'd200, 16'd7);
    repeat (2) begin @(posedge clk); #1; end
    b8.start = 1'b1; b8.signed_mode = 1'b1; b8.dividend = 8'd99; b8.divisor = 8'd5;
    @(posedge clk);
    #1;
    b8.start = 1'b0;
    wait_done(0, n, bc);
    check("mid_lat", 32'(n), 32'd6);
    check("mid_q", q_of(0), 32'd28);
    check("mid_r", r_of(0), 32'd4);
    count_done(12, d);
    check("mid_extra_done", 32'(d), 32'd0);
    check("mid_idle", 32'(b8.busy), 32'd0);
    go(0, 1'b0, 16'd100, 16'd7);
    wait_done(0, n, bc);
    check("b2b1_q", q_of(0), 32'd14);
    check("b2b1_r", r_of(0), 32'd2);
    go(0, 1'b0, 16'd10, 16'd3);
    check("b2b_accept", 32'(b8.busy), 32'd1);
    wait_done(0, n, bc);
    check("b2b2_lat", 32'(n), 32'd9);
    check("b2b2_q", q_of(0), 32'd3);
    check("b2b2_r", r_of(0), 32'd1);
    go(0, 1'b0, 16'd200, 16'd7);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_q", q_of(0), 32'd0);
    check("arst_r", r_of(0), 32'd0);
    check("arst_busy", 32'(b8.busy), 32'd0);
    check("arst_done", 32'(b8.done), 32'd0);
    check("arst_dz", z_of(0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(15, d);
    check("arst_no_done", 32'(d), 32'd0);
    run(0, "u100_10", 1'b0, 16'd100, 16'd10);
    check("u100_10_qc", q_of(0), 32'd10);
    check("u100_10_rc", r_of(0), 32'd0);
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          run(1, "w4", m[0], 16'(a), 16'(b));
    for (int i = 0; i < 150; i++)
      run(2, "w16", 1'($urandom), 16'($urandom), $urandom_range(0, 7) == 0 ? 16'd0 : 16'($urandom));
    run(2, "w16ovf", 1'b1, 16'h8000, 16'hFFFF);
    for (int i = 0; i < 60; i++)
      run(0, "w8rnd", 1'($urandom), 16'($urandom), 16'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
